edge_frame_writer: RTL

//  Write side of the ping-pong 1-bit edge frame buffer that the VGA display side reads from.

---
 rtl/edge_frame_if.sv | 27 ++
 rtl/edge_frame_writer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/edge_frame_if.sv
// Bundle between the edge-pixel source / display side and the edge frame writer.
// master = source and display side, slave = edge_frame_writer.
interface edge_frame_if #(
   parameter int ADDR_W = 16
);
   logic              din;
   logic              din_vld;
   logic              din_sop;
   logic              din_eop;
   logic              rd_end;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_data;
   logic              wr_addr_sel;
   logic              wr_end;
   logic              frame_err;

   modport master (
      output din, din_vld, din_sop, din_eop, rd_end,
      input  wr_en, wr_addr, wr_data, wr_addr_sel, wr_end, frame_err
   );

   modport slave (
      input  din, din_vld, din_sop, din_eop, rd_end,
      output wr_en, wr_addr, wr_data, wr_addr_sel, wr_end, frame_err
   );
endinterface

// File: rtl/edge_frame_writer.sv
// Write side of the ping-pong 1-bit edge frame buffer.
// Stores a raster-ordered pixel stream into the bank not being displayed,
// holds wr_end once a full COL x ROW frame is stored, and swaps banks only
// when the display side's rd_end pulse meets wr_end high.
module edge_frame_writer #(
   parameter int COL    = 320,
   parameter int ROW    = 200,
   parameter int ADDR_W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   edge_frame_if.slave  bus
);

   localparam int COL_W = (COL > 1) ? $clog2(COL) : 1;
   localparam int ROW_W = (ROW > 1) ? $clog2(ROW) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state_q,     state_d;
   logic [COL_W-1:0]  cnt_col_q,   cnt_col_d;
   logic [ROW_W-1:0]  cnt_row_q,   cnt_row_d;
   // COL*cnt_row kept as a running sum so the address path has no multiplier
   logic [ADDR_W-1:0] row_base_q,  row_base_d;
   logic              wr_en_q,     wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
   logic              wr_data_q,   wr_data_d;
   logic              wr_sel_q,    wr_sel_d;
   logic              wr_end_q,    wr_end_d;
   logic              frame_err_q, frame_err_d;

   logic col_last_s;
   logic last_pix_s;

   assign col_last_s = (cnt_col_q == COL_W'(COL - 1));
   assign last_pix_s = col_last_s && (cnt_row_q == ROW_W'(ROW - 1));

   // Next-state, counter and registered-output computation
   always_comb begin
      state_d     = state_q;
      cnt_col_d   = cnt_col_q;
      cnt_row_d   = cnt_row_q;
      row_base_d  = row_base_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      wr_sel_d    = wr_sel_q;
      wr_end_d    = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.din_vld && bus.din_sop) begin
               // pixel 0; next expected position is col 1, row 0
               wr_en_d    = 1'b1;
               wr_addr_d  = {ADDR_W{1'b0}};
               wr_data_d  = bus.din;
               cnt_col_d  = COL_W'(1);
               cnt_row_d  = {ROW_W{1'b0}};
               row_base_d = {ADDR_W{1'b0}};
               state_d    = S_WRITE;
            end else begin
               state_d    = S_IDLE;
            end
         end
         S_WRITE: begin
            if (bus.din_vld) begin
               wr_en_d   = 1'b1;
               wr_data_d = bus.din;
               if (bus.din_sop) begin
                  // unexpected start: resync, this beat becomes pixel 0
                  frame_err_d = 1'b1;
                  wr_addr_d   = {ADDR_W{1'b0}};
                  cnt_col_d   = COL_W'(1);
                  cnt_row_d   = {ROW_W{1'b0}};
                  row_base_d  = {ADDR_W{1'b0}};
               end else begin
                  wr_addr_d = row_base_q + ADDR_W'(cnt_col_q);
                  if (last_pix_s) begin
                     state_d    = S_DONE;
                     cnt_col_d  = {COL_W{1'b0}};
                     cnt_row_d  = {ROW_W{1'b0}};
                     row_base_d = {ADDR_W{1'b0}};
                  end else if (bus.din_eop) begin
                     // short frame: pixel kept, frame abandoned
                     frame_err_d = 1'b1;
                     state_d     = S_IDLE;
                     cnt_col_d   = {COL_W{1'b0}};
                     cnt_row_d   = {ROW_W{1'b0}};
                     row_base_d  = {ADDR_W{1'b0}};
                  end else if (col_last_s) begin
                     cnt_col_d  = {COL_W{1'b0}};
                     cnt_row_d  = cnt_row_q + ROW_W'(1);
                     row_base_d = row_base_q + ADDR_W'(COL);
                  end else begin
                     cnt_col_d  = cnt_col_q + COL_W'(1);
                  end
               end
            end else begin
               state_d = S_WRITE;
            end
         end
         S_DONE: begin
            // wr_end_q is still low on the strobe cycle, so an rd_end there cannot swap
            if (bus.rd_end && wr_end_q) begin
               wr_sel_d = ~wr_sel_q;
               wr_end_d = 1'b0;
               state_d  = S_IDLE;
            end else begin
               wr_end_d = 1'b1;
            end
         end
         default: begin
            state_d    = S_IDLE;
            cnt_col_d  = {COL_W{1'b0}};
            cnt_row_d  = {ROW_W{1'b0}};
            row_base_d = {ADDR_W{1'b0}};
         end
      endcase
   end

   // State, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_col_q   <= {COL_W{1'b0}};
         cnt_row_q   <= {ROW_W{1'b0}};
         row_base_q  <= {ADDR_W{1'b0}};
         wr_en_q     <= 1'b0;
         wr_addr_q   <= {ADDR_W{1'b0}};
         wr_data_q   <= 1'b0;
         wr_sel_q    <= 1'b0;
         wr_end_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_col_q   <= cnt_col_d;
         cnt_row_q   <= cnt_row_d;
         row_base_q  <= row_base_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wr_sel_q    <= wr_sel_d;
         wr_end_q    <= wr_end_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.wr_en       = wr_en_q;
   assign bus.wr_addr     = wr_addr_q;
   assign bus.wr_data     = wr_data_q;
   assign bus.wr_addr_sel = wr_sel_q;
   assign bus.wr_end      = wr_end_q;
   assign bus.frame_err   = frame_err_q;

endmodule
